cache_line_fill_ctrl: RTL and testbench

- Per-miss line fill/eviction sequencer sitting directly downstream of the replacement-policy block (LFSR or pseudo-LRU).
- On a cache miss it latches the one-hot victim way; if the victim is dirty it writes back the old line in bus beats, then fetches the new line in bus beats.
- It commits the new line into the chosen way and pulses SetValid/LRUWriteEn back to the tag array and replacement policy.
- It holds the pipeline stalled for the whole transaction.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/cache_beat_counter.sv | 35 +++
 rtl/cache_line_fill_ctrl.sv | 146 ++++++++++++++
 tb/tb_cache_line_fill_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the cache line fill/eviction sequencer:
//   fill_state_e   - sequencer states
//   calc_beats     - bus beats per cache line
//   calc_logbeats  - width of a beat index
//   beat_offset    - bit offset of a beat inside a line (beat 0 = LSBs)
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        COMMIT    = 2'd3
    } fill_state_e;

    function automatic int calc_beats(input int linelen, input int beatw);
        return linelen / beatw;
    endfunction

    function automatic int calc_logbeats(input int linelen, input int beatw);
        return $clog2(linelen / beatw);
    endfunction

    function automatic int beat_offset(input int beat, input int beatw);
        return beat * beatw;
    endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// -----------------------------------------------------------------------------
// cache_beat_counter
// Beat index counter for line transfers.
//   clk, reset (async, active-low)
//   en        - advance one beat
//   clr       - return to beat 0 (wins over en)
//   count     - current beat index
//   last_beat - count is at the final beat of the line
// The beat count per line is a power of two, so the counter wraps to 0 on
// its own after the last beat; no explicit terminal reload is needed.
// -----------------------------------------------------------------------------
module cache_beat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last_beat
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign last_beat = &count;

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_line_fill_ctrl
// Per-miss line fill / eviction sequencer. On an accepted miss it latches the
// victim way and line, writes the old line back beat by beat if dirty, fetches
// the new line beat by beat, then commits it with a one-cycle strobe set.
//
// Ports
//   clk, reset (async, active-low)
//   MissReq, FlushStage          - miss request / flush of requesting stage
//   VictimWay/Dirty/Line         - victim info, sampled only at accept
//   BusAck, BusRData             - beat handshake and read data
//   BusReq, BusWrite, BusWData   - bus transaction, direction, write data
//   BeatCount                    - current beat index
//   FillWay, FillLine            - latched victim way, assembled line
//   LineWriteEn, SetValid,
//   ClearDirty, LRUWriteEn       - one-cycle commit strobes
//   Stall                        - hold the pipeline
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for MissReq & ~FlushStage
// WRITEBACK | writing dirty victim line to the bus, one beat per BusAck
// FETCH     | reading the new line from the bus, one beat per BusAck
// COMMIT    | single-cycle write of FillLine into FillWay
// -----------------------------------------------------------------------------
module cache_line_fill_ctrl
    import cache_pkg::*;
#(
    parameter  int NUMWAYS  = 4,
    parameter  int LINELEN  = 256,
    parameter  int BEATW    = 64,
    localparam int BEATS    = calc_beats(LINELEN, BEATW),
    localparam int LOGBEATS = calc_logbeats(LINELEN, BEATW)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MissReq,
    input  logic                FlushStage,
    input  logic [NUMWAYS-1:0]  VictimWay,
    input  logic                VictimDirty,
    input  logic [LINELEN-1:0]  VictimLine,
    input  logic                BusAck,
    input  logic [BEATW-1:0]    BusRData,
    output logic                BusReq,
    output logic                BusWrite,
    output logic [BEATW-1:0]    BusWData,
    output logic [LOGBEATS-1:0] BeatCount,
    output logic [NUMWAYS-1:0]  FillWay,
    output logic [LINELEN-1:0]  FillLine,
    output logic                LineWriteEn,
    output logic                SetValid,
    output logic                ClearDirty,
    output logic                LRUWriteEn,
    output logic                Stall
);

    fill_state_e          state, state_nxt;
    logic [LINELEN-1:0]   wb_buf;
    logic                 accept;
    logic                 last_beat;
    logic                 beat_en;
    logic                 commit;

    assign accept  = (state == IDLE) && MissReq && !FlushStage;
    assign beat_en = ((state == WRITEBACK) || (state == FETCH)) && BusAck;

    cache_beat_counter #(
        .W (LOGBEATS)
    ) u_beat_counter (
        .clk       (clk),
        .reset     (reset),
        .en        (beat_en),
        .clr       (accept),
        .count     (BeatCount),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        BusReq    = 1'b0;
        BusWrite  = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = VictimDirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                BusReq   = 1'b1;
                BusWrite = 1'b1;
                if (BusAck && last_beat) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                BusReq = 1'b1;
                if (BusAck && last_beat) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Victim data is captured once at accept so later changes on the
    // replacement/data-array side cannot corrupt an in-flight writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            FillWay  <= '0;
            FillLine <= '0;
            wb_buf   <= '0;
        end else begin
            if (accept) begin
                FillWay <= VictimWay;
                wb_buf  <= VictimLine;
            end
            if ((state == FETCH) && BusAck) begin
                FillLine[beat_offset(int'(BeatCount), BEATW) +: BEATW] <= BusRData;
            end
        end
    end

    assign BusWData    = BusWrite ? wb_buf[beat_offset(int'(BeatCount), BEATW) +: BEATW]
                                  : '0;
    assign LineWriteEn = commit;
    assign SetValid    = commit;
    assign ClearDirty  = commit;
    assign LRUWriteEn  = commit;
    assign Stall       = accept || (state != IDLE);

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_line_fill_ctrl
// Directed + randomized bench for cache_line_fill_ctrl. A transaction-level
// model (beats left to write, beats left to read, commit pending) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_cache_line_fill_ctrl;

    localparam int NUMWAYS = 4;
    localparam int LINELEN = 256;
    localparam int BEATW   = 64;
    localparam int BEATS   = LINELEN / BEATW;

    logic               clk = 1'b0;
    logic               reset;
    logic               MissReq, FlushStage, VictimDirty, BusAck;
    logic [NUMWAYS-1:0] VictimWay;
    logic [LINELEN-1:0] VictimLine;
    logic [BEATW-1:0]   BusRData;
    logic               BusReq, BusWrite, LineWriteEn, SetValid, ClearDirty, LRUWriteEn, Stall;
    logic [BEATW-1:0]   BusWData;
    logic [1:0]         BeatCount;
    logic [NUMWAYS-1:0] FillWay;
    logic [LINELEN-1:0] FillLine;

    always #5 clk = ~clk;

    cache_line_fill_ctrl #(
        .NUMWAYS (NUMWAYS),
        .LINELEN (LINELEN),
        .BEATW   (BEATW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MissReq     (MissReq),
        .FlushStage  (FlushStage),
        .VictimWay   (VictimWay),
        .VictimDirty (VictimDirty),
        .VictimLine  (VictimLine),
        .BusAck      (BusAck),
        .BusRData    (BusRData),
        .BusReq      (BusReq),
        .BusWrite    (BusWrite),
        .BusWData    (BusWData),
        .BeatCount   (BeatCount),
        .FillWay     (FillWay),
        .FillLine    (FillLine),
        .LineWriteEn (LineWriteEn),
        .SetValid    (SetValid),
        .ClearDirty  (ClearDirty),
        .LRUWriteEn  (LRUWriteEn),
        .Stall       (Stall)
    );

    int errors = 0;
    int checks = 0;

    // reference model
    logic [NUMWAYS-1:0] m_way  = '0;
    logic [LINELEN-1:0] m_line = '0;
    logic [LINELEN-1:0] m_fill = '0;
    int                 m_wleft = 0;
    int                 m_rleft = 0;
    bit                 m_commit = 1'b0;

    int lwe_count;
    bit last_lwe;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_idle();
        return (m_wleft == 0) && (m_rleft == 0) && !m_commit;
    endfunction

    function automatic logic [LINELEN-1:0] rand_line();
        logic [LINELEN-1:0] r;
        for (int i = 0; i < LINELEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [NUMWAYS-1:0] rand_onehot();
        return 4'(1) << $urandom_range(0, NUMWAYS - 1);
    endfunction

    task automatic model_reset();
        m_way    = '0;
        m_fill   = '0;
        m_wleft  = 0;
        m_rleft  = 0;
        m_commit = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check 1 ns later, update model at posedge.
    task automatic step(input logic miss, input logic flush, input logic [NUMWAYS-1:0] way,
                        input logic dirty, input logic [LINELEN-1:0] line,
                        input logic ack, input logic [BEATW-1:0] rdata);
        logic e_req, e_wr, e_commit, e_stall;
        int   e_cnt;
        MissReq     = miss;
        FlushStage  = flush;
        VictimWay   = way;
        VictimDirty = dirty;
        VictimLine  = line;
        BusAck      = ack;
        BusRData    = rdata;
        #1;
        e_req = 1'b0; e_wr = 1'b0; e_commit = 1'b0; e_cnt = 0;
        if (m_commit) begin
            e_commit = 1'b1;
            e_stall  = 1'b1;
        end else if (m_wleft > 0) begin
            e_req = 1'b1; e_wr = 1'b1; e_stall = 1'b1; e_cnt = BEATS - m_wleft;
        end else if (m_rleft > 0) begin
            e_req = 1'b1; e_stall = 1'b1; e_cnt = BEATS - m_rleft;
        end else begin
            e_stall = miss && !flush;
        end
        chk("stall",       256'(Stall),       256'(e_stall));
        chk("busreq",      256'(BusReq),      256'(e_req));
        chk("buswrite",    256'(BusWrite),    256'(e_wr));
        chk("beatcount",   256'(BeatCount),   256'(e_cnt));
        chk("linewriteen", 256'(LineWriteEn), 256'(e_commit));
        chk("setvalid",    256'(SetValid),    256'(e_commit));
        chk("cleardirty",  256'(ClearDirty),  256'(e_commit));
        chk("lruwriteen",  256'(LRUWriteEn),  256'(e_commit));
        chk("fillway",     256'(FillWay),     256'(m_way));
        chk("fillway_onehot0", 256'($onehot0(FillWay)), 256'(1));
        if (e_wr) chk("buswdata", 256'(BusWData), 256'(m_line[e_cnt*BEATW +: BEATW]));
        if (e_commit) chk("fillline", FillLine, m_fill);
        last_lwe = LineWriteEn;
        if (LineWriteEn) lwe_count++;
        @(posedge clk);
        if (m_commit) begin
            m_commit = 1'b0;
        end else if (m_wleft > 0) begin
            if (ack) m_wleft--;
        end else if (m_rleft > 0) begin
            if (ack) begin
                m_fill[(BEATS - m_rleft)*BEATW +: BEATW] = rdata;
                m_rleft--;
                if (m_rleft == 0) m_commit = 1'b1;
            end
        end else if (miss && !flush) begin
            m_way   = way;
            m_line  = line;
            m_wleft = dirty ? BEATS : 0;
            m_rleft = BEATS;
        end
        @(negedge clk);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, rand_onehot(), 1'($urandom_range(0, 1)), rand_line(), 1'b0, 64'h0);
    endtask

    // ackmode: 0 always, 1 random, 2 pattern 1,0,0
    // rmode:   0 data = 0xA0 + beat, 1 random
    // flushmode: 0 none, 1 random, 2 during fetch beat 2
    task automatic txn(input string tag, input logic [NUMWAYS-1:0] way, input logic dirty,
                       input logic [LINELEN-1:0] line, input int ackmode, input int rmode,
                       input int flushmode, input bit vchange);
        int k, commit_at;
        logic ack, fl;
        logic [BEATW-1:0] rd;
        lwe_count = 0;
        commit_at = -1;
        step(1'b1, 1'b0, way, dirty, line, 1'b1, 64'h0);
        k = 1;
        while (!model_idle() && k < 80) begin
            ack = (ackmode == 0) ? 1'b1 :
                  (ackmode == 2) ? ((k % 3) == 1) : 1'($urandom_range(0, 1));
            rd  = (rmode == 0) ? (64'hA0 + 64'(BEATS - m_rleft)) : {$urandom, $urandom};
            fl  = (flushmode == 1) ? 1'($urandom_range(0, 1)) :
                  (flushmode == 2) ? ((m_wleft == 0) && (m_rleft == 2)) : 1'b0;
            step(1'($urandom_range(0, 1)), fl, vchange ? 4'b1000 : rand_onehot(),
                 1'($urandom_range(0, 1)), rand_line(), ack, rd);
            if (last_lwe) commit_at = k;
            k++;
        end
        chk({tag, "_completed"}, 256'(model_idle()), 256'(1));
        chk({tag, "_one_commit"}, 256'(lwe_count), 256'(1));
        if (ackmode == 0) chk({tag, "_commit_cycle"}, 256'(commit_at), 256'(dirty ? 9 : 5));
        step(1'b0, 1'b0, rand_onehot(), 1'b0, rand_line(), 1'b0, 64'h0);
    endtask

    initial begin
        reset = 1'b0; MissReq = 1'b0; FlushStage = 1'b0; VictimWay = '0; VictimDirty = 1'b0;
        VictimLine = '0; BusAck = 1'b0; BusRData = '0;
        #1;
        chk("rst_busreq",    256'(BusReq),      256'(0));
        chk("rst_buswrite",  256'(BusWrite),    256'(0));
        chk("rst_buswdata",  256'(BusWData),    256'(0));
        chk("rst_beatcount", 256'(BeatCount),   256'(0));
        chk("rst_fillway",   256'(FillWay),     256'(0));
        chk("rst_fillline",  FillLine,          256'(0));
        chk("rst_lwe",       256'(LineWriteEn), 256'(0));
        chk("rst_stall",     256'(Stall),       256'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        idle_step();

        // clean miss, ack always high, known read data
        txn("clean", 4'b0100, 1'b0, rand_line(), 0, 0, 0, 1'b0);
        chk("clean_fillline", FillLine, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        chk("clean_fillway", 256'(FillWay), 256'(4'b0100));

        // dirty miss with patterned victim line
        txn("dirty", 4'b0010, 1'b1,
            {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
            0, 1, 0, 1'b0);

        // ack gaps during transfer
        txn("ackgap", 4'b1000, 1'b0, rand_line(), 2, 1, 0, 1'b0);

        // flush in idle: no accept
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, rand_onehot(), 1'b1, rand_line(), 1'b1, 64'h0);
            chk("flush_idle_stall", 256'(Stall), 256'(0));
        end

        // flush during fetch beat 2 is ignored
        txn("flushfetch", 4'b0001, 1'b1, rand_line(), 1, 1, 2, 1'b0);

        // victim changes after accept have no effect
        txn("vchange", 4'b0001, 1'b1, rand_line(), 1, 1, 0, 1'b1);
        chk("vchange_fillway", 256'(FillWay), 256'(4'b0001));

        // async reset in the middle of writeback beat 1
        step(1'b1, 1'b0, 4'b0010, 1'b1, rand_line(), 1'b1, 64'h0);
        step(1'b0, 1'b0, 4'b0100, 1'b0, rand_line(), 1'b1, 64'h0);
        MissReq = 1'b0; BusAck = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("midrst_busreq",    256'(BusReq),      256'(0));
        chk("midrst_fillway",   256'(FillWay),     256'(0));
        chk("midrst_fillline",  FillLine,          256'(0));
        chk("midrst_buswdata",  256'(BusWData),    256'(0));
        chk("midrst_beatcount", 256'(BeatCount),   256'(0));
        chk("midrst_lwe",       256'(LineWriteEn), 256'(0));
        chk("midrst_stall",     256'(Stall),       256'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) idle_step();

        // randomized transactions
        for (int i = 0; i < 6; i++) begin
            txn("rand", rand_onehot(), 1'($urandom_range(0, 1)), rand_line(), 1, 1, 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
